// File: rtl/dm_stage.sv
// MEM-stage data path: data memory, store byte merging, load extension,
// address-exception detection and timer-device forwarding.
module dm_stage #(
  parameter int unsigned DM_WORDS  = 3072,
  parameter logic [31:0] DEV0_BASE = 32'h0000_7F00,
  parameter logic [31:0] DEV1_BASE = 32'h0000_7F10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic [31:0] PC,
  input  logic [3:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] dev_rdata,
  output logic [31:0] dout,
  output logic        exc,
  output logic [4:0]  exc_code,
  output logic [31:0] exc_pc,
  output logic [31:0] dev_addr,
  output logic        dev_we,
  output logic [31:0] dev_wdata,
  output logic        last_we,
  output logic [31:0] last_waddr,
  output logic [31:0] last_wdata
);

  localparam int unsigned IDX_W    = $clog2(DM_WORDS);
  localparam logic [31:0] DM_LIMIT = 32'(DM_WORDS) << 2;

  typedef enum logic [3:0] {
    OP_NONE = 4'd0,
    OP_LW   = 4'd1,
    OP_LH   = 4'd2,
    OP_LHU  = 4'd3,
    OP_LB   = 4'd4,
    OP_LBU  = 4'd5,
    OP_SW   = 4'd6,
    OP_SH   = 4'd7,
    OP_SB   = 4'd8
  } op_e;

  logic [31:0]      mem [DM_WORDS];
  logic [IDX_W-1:0] idx;
  logic             in_dm, in_dev0, in_dev1, in_dev, unmapped, count_word;
  logic [31:0]      dev_off;
  logic             is_load, is_store, mis, sub;
  logic             exc_load, exc_store, dm_we;
  logic [3:0]       be;
  logic [31:0]      lane_data, rd_word, wr_word, src;
  logic [15:0]      half;
  logic [7:0]       byte_sel;

  assign idx        = addr[IDX_W+1:2];
  assign in_dm      = addr < DM_LIMIT;
  assign in_dev0    = (addr >= DEV0_BASE) && (addr <= DEV0_BASE + 32'd11);
  assign in_dev1    = (addr >= DEV1_BASE) && (addr <= DEV1_BASE + 32'd11);
  assign in_dev     = in_dev0 | in_dev1;
  assign unmapped   = !in_dm && !in_dev;
  assign dev_off    = in_dev0 ? (addr - DEV0_BASE) : (addr - DEV1_BASE);
  assign count_word = dev_off >= 32'd8;
  assign rd_word    = in_dm ? mem[idx] : '0;

  // Classify the access: direction, sub-word size and misalignment.
  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    mis      = 1'b0;
    sub      = 1'b0;
    case (op)
      OP_LW:         begin is_load = 1'b1;  mis = |addr[1:0]; end
      OP_LH, OP_LHU: begin is_load = 1'b1;  mis = addr[0]; sub = 1'b1; end
      OP_LB, OP_LBU: begin is_load = 1'b1;  sub = 1'b1; end
      OP_SW:         begin is_store = 1'b1; mis = |addr[1:0]; end
      OP_SH:         begin is_store = 1'b1; mis = addr[0]; sub = 1'b1; end
      OP_SB:         begin is_store = 1'b1; sub = 1'b1; end
      default:       ;
    endcase
  end

  assign exc_load  = is_load  & (mis | unmapped | (in_dev & sub));
  assign exc_store = is_store & (mis | unmapped | (in_dev & (sub | count_word)));
  assign exc       = exc_load | exc_store;
  assign exc_code  = exc_load ? 5'd4 : (exc_store ? 5'd5 : '0);
  assign exc_pc    = PC;

  assign dm_we     = is_store & in_dm & !exc & !clear;
  assign dev_we    = (op == OP_SW) & in_dev & !exc & !clear;
  assign dev_addr  = addr;
  assign dev_wdata = wdata;

  // Byte enables and lane-replicated store data for the merge.
  always_comb begin
    be        = '0;
    lane_data = wdata;
    case (op)
      OP_SW:   be = '1;
      OP_SH:   begin be = addr[1] ? 4'b1100 : 4'b0011; lane_data = {2{wdata[15:0]}}; end
      OP_SB:   begin be = 4'b0001 << addr[1:0];        lane_data = {4{wdata[7:0]}};  end
      default: ;
    endcase
  end

  // Merge the selected lanes into the current word contents.
  always_comb begin
    wr_word = rd_word;
    for (int unsigned i = 0; i < 4; i++) begin
      if (be[i]) wr_word[8*i +: 8] = lane_data[8*i +: 8];
    end
  end

  // Lane selection and sign/zero extension of the load result.
  always_comb begin
    src  = in_dm ? rd_word : dev_rdata;
    half = addr[1] ? src[31:16] : src[15:0];
    case (addr[1:0])
      2'd0:    byte_sel = src[7:0];
      2'd1:    byte_sel = src[15:8];
      2'd2:    byte_sel = src[23:16];
      default: byte_sel = src[31:24];
    endcase
    case (op)
      OP_LW:   dout = src;
      OP_LH:   dout = {{16{half[15]}}, half};
      OP_LHU:  dout = {16'h0000, half};
      OP_LB:   dout = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  dout = {24'h000000, byte_sel};
      default: dout = '0;
    endcase
  end

  // Data-memory array write; reset clears every word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem <= '{default: '0};
    end else if (dm_we) begin
      mem[idx] <= wr_word;
    end
  end

  // Trace record of the last committed DM store (last_we pulses per store).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_we    <= 1'b0;
      last_waddr <= '0;
      last_wdata <= '0;
    end else begin
      last_we <= dm_we;
      if (dm_we) begin
        last_waddr <= addr;
        last_wdata <= wr_word;
      end
    end
  end

endmodule

// File: tb/tb_dm_stage.sv
// Self-checking bench for dm_stage: directed cases plus randomized accesses
// compared against a byte-addressed behavioural model.
module tb_dm_stage;

  logic        clk = 1'b0;
  logic        reset, clear;
  logic [31:0] PC, addr, wdata, dev_rdata;
  logic [3:0]  op;
  logic [31:0] dout, exc_pc, dev_addr, dev_wdata, last_waddr, last_wdata;
  logic        exc, dev_we, last_we;
  logic [4:0]  exc_code;

  dm_stage #(.DM_WORDS(3072), .DEV0_BASE(32'h0000_7F00), .DEV1_BASE(32'h0000_7F10)) dut (
    .clk(clk), .reset(reset), .clear(clear), .PC(PC), .op(op), .addr(addr),
    .wdata(wdata), .dev_rdata(dev_rdata), .dout(dout), .exc(exc),
    .exc_code(exc_code), .exc_pc(exc_pc), .dev_addr(dev_addr), .dev_we(dev_we),
    .dev_wdata(dev_wdata), .last_we(last_we), .last_waddr(last_waddr),
    .last_wdata(last_wdata)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Reference model state: memory as individual bytes, plus the store trace.
  logic [7:0]  mb [int unsigned];
  logic [31:0] m_waddr = '0;
  logic [31:0] m_wdata = '0;
  bit          m_wdata_known = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic int unsigned acc_size(input logic [3:0] o);
    case (o)
      4'd1, 4'd6:       return 4;
      4'd2, 4'd3, 4'd7: return 2;
      4'd4, 4'd5, 4'd8: return 1;
      default:          return 0;
    endcase
  endfunction

  function automatic bit is_dm(input logic [31:0] a);
    return a < 32'h3000;
  endfunction

  function automatic bit is_dev(input logic [31:0] a);
    return (a >= 32'h7F00 && a < 32'h7F0C) || (a >= 32'h7F10 && a < 32'h7F1C);
  endfunction

  function automatic logic [4:0] model_exc(input logic [3:0] o, input logic [31:0] a);
    int unsigned sz = acc_size(o);
    bit load, bad;
    if (sz == 0) return 5'd0;
    load = (o <= 4'd5);
    bad  = (a % sz != 0) || (!is_dm(a) && !is_dev(a)) || (is_dev(a) && sz != 4);
    if (!load && is_dev(a) && (a % 16) >= 8) bad = 1'b1;
    return bad ? (load ? 5'd4 : 5'd5) : 5'd0;
  endfunction

  function automatic logic [7:0] rd_byte(input int unsigned a);
    return mb.exists(a) ? mb[a] : 8'h00;
  endfunction

  function automatic logic [31:0] model_load(input logic [3:0] o, input logic [31:0] a,
                                             input logic [31:0] devr);
    int unsigned sz = acc_size(o);
    longint v = 0;
    longint b;
    for (int unsigned i = 0; i < sz; i++) begin
      if (is_dm(a)) b = longint'(rd_byte(a + i));
      else          b = longint'((devr >> (8 * ((a + i) % 4))) & 32'hFF);
      v += b << (8 * i);
    end
    if ((o == 4'd2 || o == 4'd4) && v >= (longint'(1) << (8 * sz - 1)))
      v -= longint'(1) << (8 * sz);
    return 32'(v);
  endfunction

  // One access cycle: drive, check combinational outputs, clock, check trace.
  task automatic access(input logic [3:0] o, input logic [31:0] a, input logic [31:0] w,
                        input logic clr, input logic [31:0] devr);
    logic [4:0] ec;
    int unsigned sz;
    bit ex, commit, dv;
    op = o; addr = a; wdata = w; clear = clr; dev_rdata = devr; PC = $urandom;
    #2;
    ec = model_exc(o, a);
    ex = (ec != 0);
    sz = acc_size(o);
    check("exc", 32'(exc), 32'(ex));
    check("exc_code", 32'(exc_code), 32'(ec));
    check("exc_pc", exc_pc, PC);
    check("dev_addr", dev_addr, a);
    check("dev_wdata", dev_wdata, w);
    dv = (o == 4'd6) && !ex && !clr && is_dev(a);
    check("dev_we", 32'(dev_we), 32'(dv));
    if (sz == 0) check("dout_none", dout, 32'h0);
    else if (o <= 4'd5 && !ex) check("dout", dout, model_load(o, a, devr));
    commit = (sz != 0) && (o >= 4'd6) && !ex && !clr && is_dm(a);
    @(posedge clk);
    #1;
    if (commit) begin
      for (int unsigned i = 0; i < sz; i++) mb[a + i] = 8'((w >> (8 * i)) & 32'hFF);
      m_waddr = a;
      m_wdata_known = (o == 4'd6);
      m_wdata = w;
      check("last_we", 32'(last_we), 32'h1);
    end
    check("last_waddr", last_waddr, m_waddr);
    if (m_wdata_known) check("last_wdata", last_wdata, m_wdata);
  endtask

  initial begin
    logic [31:0] a;
    logic [3:0]  o;
    reset = 1'b0; clear = 1'b0; op = 4'd1; addr = 32'h10; wdata = '0;
    dev_rdata = '0; PC = '0;
    #3;
    check("rst_last_we", 32'(last_we), 32'h0);
    check("rst_last_waddr", last_waddr, 32'h0);
    check("rst_last_wdata", last_wdata, 32'h0);
    check("rst_dout", dout, 32'h0);
    #9 reset = 1'b1;
    @(posedge clk);
    #1;

    // Store/load basics and byte-lane merging.
    access(4'd6, 32'h10, 32'h12345678, 1'b0, '0);
    check("tp_waddr", last_waddr, 32'h10);
    access(4'd1, 32'h10, '0, 1'b0, '0);
    check("tp_lw", dout, 32'h12345678);
    access(4'd8, 32'h11, 32'h000000AB, 1'b0, '0);
    access(4'd4, 32'h11, '0, 1'b0, '0);
    check("tp_lb", dout, 32'hFFFFFFAB);
    access(4'd5, 32'h11, '0, 1'b0, '0);
    check("tp_lbu", dout, 32'h000000AB);
    access(4'd1, 32'h10, '0, 1'b0, '0);
    check("tp_lw_merged", dout, 32'h1234AB78);
    access(4'd7, 32'h12, 32'h00008001, 1'b0, '0);
    access(4'd2, 32'h12, '0, 1'b0, '0);
    check("tp_lh", dout, 32'hFFFF8001);
    access(4'd3, 32'h12, '0, 1'b0, '0);
    check("tp_lhu", dout, 32'h00008001);

    // Address exceptions and device accesses.
    access(4'd1, 32'h02, '0, 1'b0, '0);
    access(4'd7, 32'h03, 32'hFFFF, 1'b0, '0);
    access(4'd6, 32'h3000, 32'h1, 1'b0, '0);
    access(4'd1, 32'h10, '0, 1'b0, '0);
    check("tp_dm_unchanged", dout, 32'h8001AB78);
    access(4'd6, 32'h7F04, 32'h5, 1'b0, '0);
    access(4'd6, 32'h7F08, 32'h5, 1'b0, '0);
    access(4'd4, 32'h7F00, '0, 1'b0, 32'h80);
    access(4'd1, 32'h7F18, '0, 1'b0, 32'hA5A5_0F0F);
    access(4'd6, 32'h7F14, 32'h77, 1'b0, '0);
    access(4'd1, 32'h7F0C, '0, 1'b0, '0);
    access(4'd6, 32'h2FFC, 32'hBEEF_0001, 1'b0, '0);
    access(4'd1, 32'h2FFC, '0, 1'b0, '0);
    access(4'd1, 32'hFFFF_FFFC, '0, 1'b0, '0);

    // Flushed store leaves memory untouched.
    access(4'd6, 32'h40, 32'hDEAD_BEEF, 1'b1, '0);
    access(4'd1, 32'h40, '0, 1'b0, '0);
    check("tp_clear", dout, 32'h0);

    // Asynchronous reset between clock edges.
    access(4'd6, 32'h20, 32'hCAFE_BABE, 1'b0, '0);
    op = 4'd1; addr = 32'h20; clear = 1'b0;
    #1 reset = 1'b0;
    #1;
    check("async_dout", dout, 32'h0);
    check("async_last_we", 32'(last_we), 32'h0);
    check("async_last_waddr", last_waddr, 32'h0);
    mb.delete();
    m_waddr = '0; m_wdata = '0; m_wdata_known = 1'b1;
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    access(4'd1, 32'h20, '0, 1'b0, '0);
    access(4'd6, 32'h24, 32'h0BAD_F00D, 1'b0, '0);

    // Randomized traffic over DM, DM top boundary, devices and wild addresses.
    for (int n = 0; n < 400; n++) begin
      o = 4'($urandom_range(0, 10));
      case ($urandom_range(0, 3))
        0:       a = 32'($urandom_range(0, 63));
        1:       a = 32'h2FF0 + 32'($urandom_range(0, 31));
        2:       a = 32'h7F00 + 32'($urandom_range(0, 31));
        default: a = $urandom;
      endcase
      access(o, a, $urandom, 1'($urandom_range(0, 7) == 0), $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dm_stage.md
# dm_stage

MEM-stage data path that sits directly upstream of the MEM/WB pipeline register. Each cycle it performs the data-memory or device access for the instruction held in EX/MEM. It owns the word-addressed data memory array, byte-lane store merging, and load extension. It also flags address exceptions (AdEL/AdES) and forwards timer accesses to the system bridge. Its `dout` feeds MEM/WB's load-data input; MEM/WB selects it over ALUout for load instructions.

## Interface
- `DM_WORDS`, 3072: data-memory depth in 32-bit words; the memory covers 0x0000_0000 to 4*DM_WORDS-1.
- `DEV0_BASE`, 32'h0000_7F00: timer0 base; 3 words; word offset 2 (count) is read-only.
- `DEV1_BASE`, 32'h0000_7F10: timer1 base; same layout as timer0.
- `clk  in  1`: the single clock; all state updates occur on its rising edge.
- `reset  in  1`: asynchronous, active-low reset; 0 resets immediately, independent of `clk`.
- `clear  in  1`: synchronous flush (exception/eret); this cycle's access has no side effect.
- `PC  in  32`: PC of the MEM-stage instruction; passed through to `exc_pc`.
- `op  in  4`: access type. 0 none, 1 lw, 2 lh, 3 lhu, 4 lb, 5 lbu, 6 sw, 7 sh, 8 sb; other codes are treated as none.
- `addr  in  32`: effective address (ALUout from EX/MEM).
- `wdata  in  32`: store data, already forwarded.
- `dev_rdata  in  32`: read data returned by the bridge.
- `dout  out  32`: extended load result; combinational.
- `exc  out  1`: address exception this cycle; combinational.
- `exc_code  out  5`: 4 = AdEL, 5 = AdES, 0 otherwise.
- `exc_pc  out  32`: equal to `PC`.
- `dev_addr  out  32`, `dev_we  out  1`, `dev_wdata  out  32`: device write/read port, combinational.
- `last_we  out  1`, `last_waddr  out  32`, `last_wdata  out  32`: registered record of the most recent committed DM store. Used by the test harness for write tracing.

## Operation
- Region decode on `addr`:
  - DM: `addr` < 4*DM_WORDS.
  - DEV0: `addr` in [DEV0_BASE, DEV0_BASE+11].
  - DEV1: `addr` in [DEV1_BASE, DEV1_BASE+11].
  - Any other address is unmapped.
- Alignment rules:
  - lw/sw require `addr[1:0]`=0.
  - lh/lhu/sh require `addr[0]`=0.
  - Byte accesses are always aligned.
- AdEL is raised for a load that is misaligned, targets an unmapped address, or is a lh/lhu/lb/lbu to a device.
- AdES is raised for a store that is misaligned, targets an unmapped address, is sh/sb to a device, or is any store to a device count word (offset 8).
- An access with `exc`=1 writes nothing: no DM write, `dev_we`=0, `last_we` is not updated.
- Store merge: the byte enable is derived from `op` and `addr[1:0]`.
  - sw writes the whole word.
  - sh writes lanes {1,0} or {3,2}, using `wdata[15:0]`.
  - sb writes one lane, using `wdata[7:0]`.
  - Unselected bytes of the word keep their old value.
- Load extension: the word source is `mem[addr[31:2]]` for DM or `dev_rdata` for a device.
  - lh and lb sign-extend; lhu and lbu zero-extend.
  - Lane selection uses `addr[1:0]`, with little-endian byte order.
- `dev_we` = 1 only for a valid sw to a writable device word when `clear`=0. `dev_addr` = `addr` and `dev_wdata` = `wdata`.
- When `op` = none, `exc` is 0 and `dout` = 0.

## Timing
- DM write, `last_*` update: at the rising edge of `clk` where the store is valid, `exc`=0 and `clear`=0.
- DM read: combinational, with read-old semantics. A load in the same cycle as a store to the same word returns the pre-store value. Back-to-back store then load in consecutive cycles returns the new value.
- Asynchronous reset (`reset`=0): every DM word becomes 0; `last_we`=0, `last_waddr`=0, `last_wdata`=0. Combinational outputs then follow their inputs.
- Reset released mid-stream: the first rising edge after `reset` goes to 1 performs normal accesses. There is no startup latency.
- `clear` together with a valid store: the store is suppressed. `exc` is still reported combinationally, but upstream ignores it because of the flush.
- Address wrap: addresses at or above 4*DM_WORDS never alias into DM; they are unmapped.

## Test plan
- sw 0x12345678 to 0x10; next cycle lw 0x10 → `dout`=0x12345678; `last_waddr`=0x10.
- After the step above, sb 0xAB to 0x11; lb 0x11 → `dout`=0xFFFFFFAB; lbu → 0x000000AB; lw 0x10 → 0x1234AB78.
- sh 0x8001 to 0x12; lh 0x12 → `dout`=0xFFFF8001; lhu → 0x00008001.
- lw 0x02 → `exc`=1, `exc_code`=4, no write. sh 0x03 → `exc_code`=5, DM unchanged. sw 0x3000 → `exc_code`=5.
- sw to 0x7F04 with `wdata`=5 → `dev_we`=1, `dev_addr`=0x7F04. sw to 0x7F08 → AdES, `dev_we`=0. lb 0x7F00 → AdEL.
- Sequence: sw to 0x20, then pull `reset` low mid-cycle, then release. lw 0x20 → 0, and `last_we`=0 immediately, with no clock edge needed. Separately, a sw with `clear`=1 leaves DM unchanged.
